// File: rtl/id_issue_unit.sv
// ---------------------------------------------------------------------------
// id_issue_unit: RV32 decode/issue stage with regfile, load scoreboard,
// operand forwarding, ID branch resolution; optional ID_STALL_CNT_EN counter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module id_issue_unit #(
  parameter int DWIDTH   = 32,
  parameter int PC_WIDTH = 32,
  parameter int RA_WIDTH = 5,
  parameter int NUM_FWD  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PC_WIDTH-1:0]          in_pc,
  input  logic [RA_WIDTH-1:0]          in_rs1,
  input  logic [RA_WIDTH-1:0]          in_rs2,
  input  logic [RA_WIDTH-1:0]          in_rd,
  input  logic                         in_use_rs1,
  input  logic                         in_use_rs2,
  input  logic                         in_wb_en,
  input  logic                         in_long_lat,
  input  logic                         in_branch,
  input  logic                         in_jump,
  input  logic                         in_jalr,
  input  logic [2:0]                   in_func3,
  input  logic [DWIDTH-1:0]            in_imm,
  input  logic [NUM_FWD-1:0]           fwd_valid,
  input  logic [NUM_FWD*RA_WIDTH-1:0]  fwd_rd,
  input  logic [NUM_FWD*DWIDTH-1:0]    fwd_data,
  input  logic                         wb_en,
  input  logic [RA_WIDTH-1:0]          wb_rd,
  input  logic [DWIDTH-1:0]            wb_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_WIDTH-1:0]          out_pc,
  output logic [DWIDTH-1:0]            out_imm,
  output logic [DWIDTH-1:0]            out_rs1_data,
  output logic [DWIDTH-1:0]            out_rs2_data,
  output logic [RA_WIDTH-1:0]          out_rd,
  output logic                         out_wb_en,
  output logic                         out_long_lat,
  output logic                         redirect_valid,
  output logic [PC_WIDTH-1:0]          redirect_pc,
  output logic [31:0]                  stall_cycles
);

  localparam int NREGS = 2**RA_WIDTH;

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_REDIRECT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [DWIDTH-1:0]     rf_q [NREGS];
  logic [NREGS-1:0]      sb_q, sb_d;
  logic                  out_valid_q;
  logic [PC_WIDTH-1:0]   out_pc_q;
  logic [DWIDTH-1:0]     out_imm_q, out_rs1_q, out_rs2_q;
  logic [RA_WIDTH-1:0]   out_rd_q;
  logic                  out_wb_en_q, out_long_lat_q;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [PC_WIDTH-1:0]   redirect_pc_q, redirect_pc_d;

  logic [DWIDTH-1:0]     rs1_val, rs2_val;
  logic                  blk_rs1, blk_rs2, blk_rd, hazard, issue, taken;
  logic [PC_WIDTH-1:0]   target;

  // Priority: x0, then lowest-index forward source, then wb bypass, then regfile.
  function automatic logic [DWIDTH-1:0] sel_operand(
    input logic [RA_WIDTH-1:0]         rs,
    input logic [DWIDTH-1:0]           rf_val,
    input logic [NUM_FWD-1:0]          fv,
    input logic [NUM_FWD*RA_WIDTH-1:0] frd,
    input logic [NUM_FWD*DWIDTH-1:0]   fdat,
    input logic                        wen,
    input logic [RA_WIDTH-1:0]         wrd,
    input logic [DWIDTH-1:0]           wdat
  );
    logic [DWIDTH-1:0] r;
    r = rf_val;
    if (wen && (wrd == rs)) r = wdat;
    for (int i = NUM_FWD-1; i >= 0; i--) begin
      if (fv[i] && (frd[i*RA_WIDTH +: RA_WIDTH] == rs)) r = fdat[i*DWIDTH +: DWIDTH];
    end
    if (rs == '0) r = '0;
    return r;
  endfunction

  assign rs1_val = sel_operand(in_rs1, rf_q[in_rs1], fwd_valid, fwd_rd, fwd_data, wb_en, wb_rd, wb_data);
  assign rs2_val = sel_operand(in_rs2, rf_q[in_rs2], fwd_valid, fwd_rd, fwd_data, wb_en, wb_rd, wb_data);

  assign blk_rs1 = in_use_rs1 && (in_rs1 != '0) && sb_q[in_rs1] && !(wb_en && (wb_rd == in_rs1));
  assign blk_rs2 = in_use_rs2 && (in_rs2 != '0) && sb_q[in_rs2] && !(wb_en && (wb_rd == in_rs2));
  assign blk_rd  = in_wb_en   && (in_rd  != '0) && sb_q[in_rd]  && !(wb_en && (wb_rd == in_rd));
  assign hazard  = blk_rs1 || blk_rs2 || blk_rd;

  assign in_ready = (state_q == ST_REDIRECT) || (!hazard && (!out_valid_q || out_ready));
  assign issue    = in_valid && in_ready && (state_q == ST_RUN);

  always_comb begin
    taken = 1'b0;
    case (in_func3)
      3'b000:  taken = (rs1_val == rs2_val);
      3'b001:  taken = (rs1_val != rs2_val);
      3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  taken = (rs1_val <  rs2_val);
      3'b111:  taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    target = (in_jalr ? PC_WIDTH'(rs1_val) : in_pc) + PC_WIDTH'(in_imm);
    if (in_jalr) target[0] = 1'b0;
  end

  always_comb begin
    state_d          = state_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    case (state_q)
      ST_RUN: begin
        if (issue && (in_jump || (in_branch && taken))) begin
          redirect_valid_d = 1'b1;
          redirect_pc_d    = target;
          state_d          = ST_REDIRECT;
        end
      end
      // The instruction seen here is the wrong-path one; it is consumed only.
      ST_REDIRECT: state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  always_comb begin
    sb_d = sb_q;
    if (wb_en) sb_d[wb_rd] = 1'b0;
    if (issue && in_wb_en && in_long_lat && (in_rd != '0)) sb_d[in_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_RUN;
      sb_q             <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q          <= state_d;
      sb_q             <= sb_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      if (wb_en && (wb_rd != '0)) rf_q[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_pc_q       <= '0;
      out_imm_q      <= '0;
      out_rs1_q      <= '0;
      out_rs2_q      <= '0;
      out_rd_q       <= '0;
      out_wb_en_q    <= 1'b0;
      out_long_lat_q <= 1'b0;
    end else if (issue) begin
      out_valid_q    <= 1'b1;
      out_pc_q       <= in_pc;
      out_imm_q      <= in_imm;
      out_rs1_q      <= rs1_val;
      out_rs2_q      <= rs2_val;
      out_rd_q       <= in_rd;
      out_wb_en_q    <= in_wb_en;
      out_long_lat_q <= in_long_lat;
    end else if (out_ready && out_valid_q) begin
      out_valid_q    <= 1'b0;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_pc         = out_pc_q;
  assign out_imm        = out_imm_q;
  assign out_rs1_data   = out_rs1_q;
  assign out_rs2_data   = out_rs2_q;
  assign out_rd         = out_rd_q;
  assign out_wb_en      = out_wb_en_q;
  assign out_long_lat   = out_long_lat_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state_q == ST_RUN) && in_valid && !in_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_issue_unit.sv
// ---------------------------------------------------------------------------
// tb_id_issue_unit: directed + random checks of id_issue_unit against a model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_id_issue_unit;
  localparam int DW = 32;
  localparam int PW = 32;
  localparam int RW = 5;
  localparam int NF = 2;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready;
  logic [PW-1:0] in_pc;
  logic [RW-1:0] in_rs1, in_rs2, in_rd;
  logic in_use_rs1, in_use_rs2, in_wb_en, in_long_lat, in_branch, in_jump, in_jalr;
  logic [2:0] in_func3;
  logic [DW-1:0] in_imm;
  logic [NF-1:0] fwd_valid;
  logic [NF*RW-1:0] fwd_rd;
  logic [NF*DW-1:0] fwd_data;
  logic wb_en;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic out_valid, out_ready;
  logic [PW-1:0] out_pc;
  logic [DW-1:0] out_imm, out_rs1_data, out_rs2_data;
  logic [RW-1:0] out_rd;
  logic out_wb_en, out_long_lat, redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic [31:0] stall_cycles;

  id_issue_unit #(.DWIDTH(DW), .PC_WIDTH(PW), .RA_WIDTH(RW), .NUM_FWD(NF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_use_rs1(in_use_rs1),
    .in_use_rs2(in_use_rs2), .in_wb_en(in_wb_en), .in_long_lat(in_long_lat),
    .in_branch(in_branch), .in_jump(in_jump), .in_jalr(in_jalr), .in_func3(in_func3),
    .in_imm(in_imm), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm), .out_rs1_data(out_rs1_data),
    .out_rs2_data(out_rs2_data), .out_rd(out_rd), .out_wb_en(out_wb_en),
    .out_long_lat(out_long_lat), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural registers, pending-load set, expected ID/EX view.
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_redir;
  logic        e_valid, e_wb, e_ll, e_rv;
  logic [31:0] e_pc, e_imm, e_rs1, e_rs2, e_rpc, e_stall;
  logic [4:0]  e_rd;
  logic        last_ready;
  logic [31:0] stall0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_opnd(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    for (int i = 0; i < NF; i++)
      if (fwd_valid[i] && fwd_rd[i*RW +: RW] == rs) return fwd_data[i*DW +: DW];
    if (wb_en && wb_rd == rs) return wb_data;
    return m_regs[rs];
  endfunction

  function automatic bit m_blocked(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r] && !(wb_en && wb_rd == r);
  endfunction

  function automatic bit m_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle();
    rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_use_rs1 = 1'b0; in_use_rs2 = 1'b0; in_wb_en = 1'b0; in_long_lat = 1'b0;
    in_branch = 1'b0; in_jump = 1'b0; in_jalr = 1'b0; in_func3 = '0; in_imm = '0;
    fwd_valid = '0; fwd_rd = '0; fwd_data = '0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    out_ready = 1'b1;
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("out_pc", out_pc, e_pc);
    chk("out_imm", out_imm, e_imm);
    chk("out_rs1_data", out_rs1_data, e_rs1);
    chk("out_rs2_data", out_rs2_data, e_rs2);
    chk("out_rd", 32'(out_rd), 32'(e_rd));
    chk("out_wb_en", 32'(out_wb_en), 32'(e_wb));
    chk("out_long_lat", 32'(out_long_lat), 32'(e_ll));
    chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
    chk("redirect_pc", redirect_pc, e_rpc);
    chk("stall_cycles", stall_cycles, e_stall);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
    m_redir = 1'b0;
    e_valid = 1'b0; e_wb = 1'b0; e_ll = 1'b0; e_rv = 1'b0; e_pc = '0; e_imm = '0;
    e_rs1 = '0; e_rs2 = '0; e_rpc = '0; e_stall = '0; e_rd = '0;
    check_outputs();
  endtask

  // Inputs are driven at the negedge; one call evaluates one posedge.
  task automatic cycle();
    logic rdy, iss;
    logic [31:0] a, b, tgt;
    #1;
    a   = m_opnd(in_rs1);
    b   = m_opnd(in_rs2);
    rdy = m_redir || (!((in_use_rs1 && m_blocked(in_rs1)) || (in_use_rs2 && m_blocked(in_rs2)) ||
                        (in_wb_en && m_blocked(in_rd))) && (!e_valid || out_ready));
    last_ready = in_ready;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    iss = in_valid && rdy && !m_redir;
    tgt = (in_jalr ? a : in_pc) + in_imm;
    if (in_jalr) tgt[0] = 1'b0;
`ifdef ID_STALL_CNT_EN
    if (!m_redir && in_valid && !rdy && e_stall != 32'hFFFF_FFFF) e_stall = e_stall + 1;
`endif
    if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
    if (wb_en) m_busy[wb_rd] = 1'b0;
    if (iss && in_wb_en && in_long_lat && in_rd != 5'd0) m_busy[in_rd] = 1'b1;
    if (iss) begin
      e_valid = 1'b1; e_pc = in_pc; e_imm = in_imm; e_rs1 = a; e_rs2 = b;
      e_rd = in_rd; e_wb = in_wb_en; e_ll = in_long_lat;
    end else if (out_ready && e_valid) begin
      e_valid = 1'b0;
    end
    e_rv = iss && (in_jump || (in_branch && m_taken(in_func3, a, b)));
    if (e_rv) e_rpc = tgt;
    m_redir = e_rv;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    idle();
    do_reset();

    // Forwarding priority
    idle(); in_valid = 1'b1; in_use_rs1 = 1'b1; in_rs1 = 5'd5;
    fwd_valid = 2'b11; fwd_rd = {5'd5, 5'd5}; fwd_data = {32'h22, 32'h11};
    cycle(); chk("fwd_prio_both", out_rs1_data, 32'h11);
    fwd_valid = 2'b10;
    cycle(); chk("fwd_prio_src1", out_rs1_data, 32'h22);
    in_rs1 = 5'd0;
    cycle(); chk("fwd_x0", out_rs1_data, 32'h0);

    // Load-use stall released by the matching writeback
    idle(); in_valid = 1'b1; in_wb_en = 1'b1; in_long_lat = 1'b1; in_rd = 5'd7;
    cycle();
    idle(); in_valid = 1'b1; in_use_rs2 = 1'b1; in_rs2 = 5'd7;
    cycle(); chk("loaduse_stall0", 32'(last_ready), 32'd0);
    cycle(); chk("loaduse_stall1", 32'(last_ready), 32'd0);
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD;
    cycle(); chk("loaduse_release", 32'(last_ready), 32'd1);
    chk("loaduse_data", out_rs2_data, 32'hDEAD);
    idle(); in_valid = 1'b1; in_use_rs2 = 1'b1; in_rs2 = 5'd7;
    cycle(); chk("loaduse_sb_clear", 32'(last_ready), 32'd1);

    // Taken BEQ, wrong-path drop, then not-taken BLTU
    idle(); in_valid = 1'b1; in_pc = 32'h100; in_imm = 32'h20; in_branch = 1'b1;
    in_use_rs1 = 1'b1; in_use_rs2 = 1'b1; in_rs1 = 5'd3; in_rs2 = 5'd3;
    cycle(); chk("beq_rv", 32'(redirect_valid), 32'd1); chk("beq_pc", redirect_pc, 32'h120);
    idle(); in_valid = 1'b1; in_pc = 32'h104; in_wb_en = 1'b1; in_rd = 5'd4;
    cycle(); chk("drop_ready", 32'(last_ready), 32'd1); chk("drop_valid", 32'(out_valid), 32'd0);
    chk("redirect_one_cycle", 32'(redirect_valid), 32'd0);
    idle(); in_valid = 1'b1; in_pc = 32'h100; in_imm = 32'h20; in_branch = 1'b1; in_func3 = 3'b110;
    in_use_rs1 = 1'b1; in_use_rs2 = 1'b1; in_rs1 = 5'd1; in_rs2 = 5'd2;
    fwd_valid = 2'b11; fwd_rd = {5'd2, 5'd1}; fwd_data = {32'h1, 32'hFFFF_FFFF};
    cycle(); chk("bltu_not_taken", 32'(redirect_valid), 32'd0);

    // JALR clears bit 0
    idle(); in_valid = 1'b1; in_jump = 1'b1; in_jalr = 1'b1; in_use_rs1 = 1'b1; in_rs1 = 5'd1;
    in_pc = 32'h300; in_imm = 32'h4; fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd1}; fwd_data = {32'h0, 32'h2001};
    cycle(); chk("jalr_rv", 32'(redirect_valid), 32'd1); chk("jalr_pc", redirect_pc, 32'h2004);
    idle(); cycle();

    // Backpressure holds ID/EX and counts stalls
    idle(); in_valid = 1'b1; in_pc = 32'h500; in_wb_en = 1'b1; in_rd = 5'd2;
    cycle();
    stall0 = stall_cycles;
    in_pc = 32'h504; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle(); chk("bp_ready", 32'(last_ready), 32'd0); chk("bp_hold_pc", out_pc, 32'h500);
    end
`ifdef ID_STALL_CNT_EN
    chk("bp_stall_cnt", stall_cycles, stall0 + 32'd3);
`else
    chk("bp_stall_cnt", stall_cycles, 32'd0);
`endif
    out_ready = 1'b1;
    cycle(); chk("bp_release_pc", out_pc, 32'h504);

    // Same-cycle scoreboard set and clear: set wins
    idle(); in_valid = 1'b1; in_wb_en = 1'b1; in_long_lat = 1'b1; in_rd = 5'd9;
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
    cycle();
    idle(); in_valid = 1'b1; in_use_rs1 = 1'b1; in_rs1 = 5'd9;
    cycle(); chk("sb_set_wins", 32'(last_ready), 32'd0);
    idle(); wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h123;
    cycle();

    // Reset drops a redirect being registered and clears pending loads
    idle(); in_valid = 1'b1; in_wb_en = 1'b1; in_long_lat = 1'b1; in_rd = 5'd10;
    cycle();
    idle(); in_valid = 1'b1; in_jump = 1'b1; in_pc = 32'h40; in_imm = 32'h8;
    do_reset();
    chk("rst_drop_redirect", 32'(redirect_valid), 32'd0);
    idle(); in_valid = 1'b1; in_use_rs1 = 1'b1; in_rs1 = 5'd10;
    cycle(); chk("rst_sb_clear", 32'(last_ready), 32'd1);

    // Random traffic on a small register window to force collisions
    for (int n = 0; n < 400; n++) begin
      idle();
      in_valid    = ($urandom_range(0, 3) != 0);
      in_pc       = $urandom & 32'hFFFF_FFFC;
      in_rs1      = 5'($urandom_range(0, 7));
      in_rs2      = 5'($urandom_range(0, 7));
      in_rd       = 5'($urandom_range(0, 7));
      in_use_rs1  = 1'($urandom);
      in_use_rs2  = 1'($urandom);
      in_wb_en    = 1'($urandom);
      in_long_lat = ($urandom_range(0, 3) == 0);
      in_branch   = ($urandom_range(0, 4) == 0);
      in_jump     = !in_branch && ($urandom_range(0, 9) == 0);
      in_jalr     = in_jump && 1'($urandom);
      in_func3    = 3'($urandom);
      in_imm      = $urandom;
      fwd_valid   = 2'($urandom);
      fwd_rd      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwd_data    = {$urandom, $urandom};
      wb_en       = ($urandom_range(0, 2) == 0);
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      out_ready   = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_issue_unit.md
Name: id_issue_unit

Overview:
Parametrised decode/issue stage for the pipelined RV32 core. It holds the register file and a per-register scoreboard for long-latency (load) results, and selects operands from N forwarding sources. It resolves branches and jumps in ID, issuing a registered redirect. It sits between the IF/ID register (valid/ready in) and the ID/EX register, which it owns (valid/ready out).

Parameters:
DWIDTH, 32, data and register width
PC_WIDTH, 32, program counter width
RA_WIDTH, 5, register address width; NREGS = 2**RA_WIDTH
NUM_FWD, 2, number of forwarding sources; index 0 has highest priority

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  decoded instruction valid
in_ready  out  1  ID accepts instruction this cycle
in_pc  in  PC_WIDTH  instruction PC
in_rs1, in_rs2, in_rd  in  RA_WIDTH each  register addresses
in_use_rs1, in_use_rs2  in  1 each  operand actually read
in_wb_en  in  1  instruction writes rd
in_long_lat  in  1  result arrives only via wb port (load)
in_branch, in_jump, in_jalr  in  1 each  control class
in_func3  in  3  branch condition
in_imm  in  DWIDTH  immediate
fwd_valid  in  NUM_FWD  forwarding source valid
fwd_rd  in  NUM_FWD*RA_WIDTH  forwarding destinations, packed
fwd_data  in  NUM_FWD*DWIDTH  forwarding data, packed
wb_en, wb_rd, wb_data  in  1/RA_WIDTH/DWIDTH  register-file write port
out_valid  out  1  ID/EX register valid
out_ready  in  1  EX accepts
out_pc, out_imm, out_rs1_data, out_rs2_data, out_rd, out_wb_en, out_long_lat  out  as inputs  ID/EX register contents
redirect_valid  out  1  one-cycle redirect pulse
redirect_pc  out  PC_WIDTH  redirect target
stall_cycles  out  32  stall counter (optional feature)

Behaviour:
- One clock, clk; reset rst is synchronous, active-high.
- Reset clears all out_* and redirect_* to 0, clears the scoreboard, clears all registers to 0, and sets the state to RUN.
- Register file: writes are synchronous on wb_en. Register 0 is never written and always reads 0.
- Operand select for each used rs:
  - rs==0 gives 0.
  - Otherwise take the lowest-index fwd source with fwd_valid and matching rd.
  - Otherwise take wb_data if wb_en and wb_rd==rs.
  - Otherwise read the register file.
- Hazard, combinational: any of the following stalls issue.
  - A used rs!=0 has its scoreboard bit set and is not matched by wb this cycle.
  - WAW: in_wb_en, in_rd!=0, the in_rd scoreboard bit is set, and there is no wb match.
- Scoreboard: bit[rd] is set on issue when in_wb_en & in_long_lat & rd!=0. It is cleared on wb_en for wb_rd. If set and clear hit the same rd in the same cycle, set wins.
- Issue = in_valid & in_ready & state==RUN.
- in_ready = (state==REDIRECT) | (!hazard & (!out_valid | out_ready)).
- ID/EX register:
  - Loads on issue.
  - If out_ready & out_valid and there is no issue, it clears out_valid; payload is held.
  - While out_valid & !out_ready, all outputs are held stable.
- Branch condition, compared on the selected operands:
  - 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - Any other func3 is not taken.
- Target = (in_jalr ? rs1 : in_pc) + in_imm, modulo 2**PC_WIDTH. For jalr, bit 0 is cleared.
- FSM:
  - RUN: on issue of in_jump, or in_branch & taken, register redirect_valid=1 and redirect_pc=target, then go to REDIRECT.
  - REDIRECT: redirect_valid is high for exactly this cycle. in_ready=1; any instruction presented is consumed and discarded (not issued, no scoreboard effect). Next state is RUN unconditionally.
  - redirect_valid is 0 in all other cycles.
- Reset mid-stall or mid-REDIRECT: reset wins, the pending redirect is dropped, and the scoreboard is cleared.

Optional Feature:
ID_STALL_CNT_EN. When defined, stall_cycles counts cycles with state==RUN & in_valid & !in_ready. It saturates at 2**32-1, is cleared by rst, and REDIRECT cycles are not counted. When undefined, stall_cycles is constant 0 and no counter logic is built.

Test Plan:
- Forward priority: fwd_valid=2'b11, both rd=5, fwd_data0=0x11, fwd_data1=0x22, issue rs1=5 -> out_rs1_data=0x11. With fwd_valid=2'b10 -> 0x22. With rs1=0 -> 0.
- Load-use: issue a load to x7, then present an instruction using rs2=7 -> in_ready=0 until the cycle wb_en=1, wb_rd=7, wb_data=0xDEAD. It issues that cycle with out_rs2_data=0xDEAD, and the scoreboard bit for x7 is clear afterwards.
- Taken branch: BEQ with pc=0x100, imm=0x20, rs1=rs2=3 -> the next cycle shows redirect_valid=1, redirect_pc=0x120. The following instruction is discarded and out_valid=0 for it. The same case with BLTU, rs1=0xFFFFFFFF, rs2=1 -> no redirect.
- JALR: rs1=0x2001, imm=0x4 -> redirect_pc=0x2004.
- Backpressure: out_ready=0 for 3 cycles -> in_ready=0 and out_* held. With ID_STALL_CNT_EN, stall_cycles increments by 3.
- Same-cycle scoreboard set/clear: issue a load to x9 while wb_en=1, wb_rd=9 -> bit 9 remains set and the next user of x9 stalls.
